// File: rtl/bitonic_sort_pipe.sv
// bitonic_sort_pipe
//   Fully pipelined bitonic sorting network. Each beat carries N keys plus a
//   per-lane tag. Every compare-exchange stage is registered. A single global
//   enable stalls the whole pipe when the output is held.
//
// Ports
//   clk, reset             clock and synchronous active-high reset
//   in_valid / in_ready    input handshake; in_ready = !out_valid || out_ready
//   in_desc                0 = ascending, 1 = descending; travels with the beat
//   in_key / in_tag        lane i at [i*W +: W]
//   out_valid / out_ready  output handshake
//   out_desc               direction the emerging beat was sorted with
//   out_key / out_tag      sorted keys; tags are permuted with their keys
//   out_lane               original input lane of each output element
//   busy                   any stage holds a valid beat
module bitonic_sort_pipe #(
    parameter int N         = 16,
    parameter int LOG_N     = 4,
    parameter int KEY_WIDTH = 16,
    parameter int TAG_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_desc,
    input  logic [0:N*KEY_WIDTH-1] in_key,
    input  logic [0:N*TAG_WIDTH-1] in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_desc,
    output logic [0:N*KEY_WIDTH-1] out_key,
    output logic [0:N*TAG_WIDTH-1] out_tag,
    output logic [0:N*LOG_N-1]     out_lane,
    output logic                   busy
);

    localparam int S  = LOG_N * (LOG_N + 1) / 2;  // total compare-exchange stages
    localparam int CW = KEY_WIDTH + LOG_N;        // composite {key, lane} width

    // Stage registers
    logic [KEY_WIDTH-1:0] key_reg  [S][N];
    logic [TAG_WIDTH-1:0] tag_reg  [S][N];
    logic [LOG_N-1:0]     lane_reg [S][N];
    logic [S-1:0]         valid_reg;
    logic [S-1:0]         desc_reg;

    // Stage sources (what feeds stage s) and compare-exchange results
    logic [KEY_WIDTH-1:0] key_src   [S][N];
    logic [TAG_WIDTH-1:0] tag_src   [S][N];
    logic [LOG_N-1:0]     lane_src  [S][N];
    logic [S-1:0]         desc_src;
    logic [KEY_WIDTH-1:0] key_next  [S][N];
    logic [TAG_WIDTH-1:0] tag_next  [S][N];
    logic [LOG_N-1:0]     lane_next [S][N];

    logic en;

    assign en       = !valid_reg[S-1] || out_ready;
    assign in_ready = en;

    // Stage 0 is fed from the ports, with the original lane index attached
    // so that equal keys still have a strict order.
    genvar gs, gp, gt, gi;
    generate
        for (gs = 0; gs < S; gs++) begin : g_src
            if (gs == 0) begin : g_first
                assign desc_src[0] = in_desc;
                for (gi = 0; gi < N; gi++) begin : g_lane
                    assign key_src[0][gi]  = in_key[gi*KEY_WIDTH +: KEY_WIDTH];
                    assign tag_src[0][gi]  = in_tag[gi*TAG_WIDTH +: TAG_WIDTH];
                    assign lane_src[0][gi] = LOG_N'(gi);
                end
            end else begin : g_chain
                assign desc_src[gs] = desc_reg[gs-1];
                for (gi = 0; gi < N; gi++) begin : g_lane
                    assign key_src[gs][gi]  = key_reg[gs-1][gi];
                    assign tag_src[gs][gi]  = tag_reg[gs-1][gi];
                    assign lane_src[gs][gi] = lane_reg[gs-1][gi];
                end
            end
        end
    endgenerate

    // Phase gp merges blocks of 2^gp elements; its substage gt compares
    // elements 2^(gp-1-gt) apart. Each output element independently decides
    // whether its pair swaps, so both elements of a pair agree.
    generate
        for (gp = 1; gp <= LOG_N; gp++) begin : g_phase
            for (gt = 0; gt < gp; gt++) begin : g_sub
                localparam int SI   = gp * (gp - 1) / 2 + gt;
                localparam int DIST = 1 << (gp - 1 - gt);
                for (gi = 0; gi < N; gi++) begin : g_cx
                    localparam int PARTNER = gi ^ DIST;
                    localparam int LO      = (gi < PARTNER) ? gi : PARTNER;
                    localparam int HI      = (gi < PARTNER) ? PARTNER : gi;
                    // Odd-numbered blocks of the current phase sort downward.
                    localparam bit BLK_DESC = ((gi >> gp) & 1) == 1;

                    logic [CW-1:0] lo_c;
                    logic [CW-1:0] hi_c;
                    logic          dir_desc;
                    logic          swap;

                    assign lo_c     = {key_src[SI][LO], lane_src[SI][LO]};
                    assign hi_c     = {key_src[SI][HI], lane_src[SI][HI]};
                    assign dir_desc = BLK_DESC ^ desc_src[SI];
                    assign swap     = dir_desc ? (lo_c < hi_c) : (lo_c > hi_c);

                    assign key_next[SI][gi]  = swap ? key_src[SI][PARTNER]  : key_src[SI][gi];
                    assign tag_next[SI][gi]  = swap ? tag_src[SI][PARTNER]  : tag_src[SI][gi];
                    assign lane_next[SI][gi] = swap ? lane_src[SI][PARTNER] : lane_src[SI][gi];
                end
            end
        end
    endgenerate

    // Whole-pipe advance on en; data moves regardless of valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= '0;
            desc_reg  <= '0;
            for (int s = 0; s < S; s++) begin
                for (int i = 0; i < N; i++) begin
                    key_reg[s][i]  <= '0;
                    tag_reg[s][i]  <= '0;
                    lane_reg[s][i] <= '0;
                end
            end
        end else if (en) begin
            valid_reg[0] <= in_valid;
            for (int s = 1; s < S; s++) begin
                valid_reg[s] <= valid_reg[s-1];
            end
            desc_reg <= desc_src;
            for (int s = 0; s < S; s++) begin
                for (int i = 0; i < N; i++) begin
                    key_reg[s][i]  <= key_next[s][i];
                    tag_reg[s][i]  <= tag_next[s][i];
                    lane_reg[s][i] <= lane_next[s][i];
                end
            end
        end
    end

    assign out_valid = valid_reg[S-1];
    assign out_desc  = desc_reg[S-1];
    assign busy      = |valid_reg;

    generate
        for (gi = 0; gi < N; gi++) begin : g_out
            assign out_key[gi*KEY_WIDTH +: KEY_WIDTH] = key_reg[S-1][gi];
            assign out_tag[gi*TAG_WIDTH +: TAG_WIDTH] = tag_reg[S-1][gi];
            assign out_lane[gi*LOG_N +: LOG_N]        = lane_reg[S-1][gi];
        end
    endgenerate

endmodule

// File: tb/tb_bitonic_sort_pipe.sv
module tb_bitonic_sort_pipe;

    localparam int N   = 16;
    localparam int LG  = 4;
    localparam int KW  = 16;
    localparam int TW  = 8;
    localparam int LAT = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance, N=16
    logic              in_valid, in_ready, in_desc;
    logic [0:N*KW-1]   in_key;
    logic [0:N*TW-1]   in_tag;
    logic              out_valid, out_ready, out_desc, busy;
    logic [0:N*KW-1]   out_key;
    logic [0:N*TW-1]   out_tag;
    logic [0:N*LG-1]   out_lane;

    // N=2 instance
    logic           s2_in_valid, s2_in_ready, s2_in_desc;
    logic [0:2*KW-1] s2_in_key, s2_out_key;
    logic [0:2*TW-1] s2_in_tag, s2_out_tag;
    logic           s2_out_valid, s2_out_ready, s2_out_desc, s2_busy;
    logic [0:1]     s2_out_lane;

    // N=8 instance
    logic           s8_in_valid, s8_in_ready, s8_in_desc;
    logic [0:8*KW-1] s8_in_key, s8_out_key;
    logic [0:8*TW-1] s8_in_tag, s8_out_tag;
    logic           s8_out_valid, s8_out_ready, s8_out_desc, s8_busy;
    logic [0:23]    s8_out_lane;

    bitonic_sort_pipe #(.N(16), .LOG_N(4), .KEY_WIDTH(16), .TAG_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_desc(in_desc),
        .in_key(in_key), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_desc(out_desc),
        .out_key(out_key), .out_tag(out_tag), .out_lane(out_lane), .busy(busy)
    );

    bitonic_sort_pipe #(.N(2), .LOG_N(1), .KEY_WIDTH(16), .TAG_WIDTH(8)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(s2_in_valid), .in_ready(s2_in_ready), .in_desc(s2_in_desc),
        .in_key(s2_in_key), .in_tag(s2_in_tag),
        .out_valid(s2_out_valid), .out_ready(s2_out_ready), .out_desc(s2_out_desc),
        .out_key(s2_out_key), .out_tag(s2_out_tag), .out_lane(s2_out_lane), .busy(s2_busy)
    );

    bitonic_sort_pipe #(.N(8), .LOG_N(3), .KEY_WIDTH(16), .TAG_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(s8_in_valid), .in_ready(s8_in_ready), .in_desc(s8_in_desc),
        .in_key(s8_in_key), .in_tag(s8_in_tag),
        .out_valid(s8_out_valid), .out_ready(s8_out_ready), .out_desc(s8_out_desc),
        .out_key(s8_out_key), .out_tag(s8_out_tag), .out_lane(s8_out_lane), .busy(s8_busy)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [0:N*KW-1] ikey;
        logic [0:N*TW-1] itag;
        logic            desc;
        logic [0:N*KW-1] ekey;
        logic [0:N*TW-1] etag;
        logic [0:N*LG-1] elane;
    } beat_t;

    // Reference: order the first n lanes by (key, lane), ascending or descending.
    function automatic void ref_order(input int n, input int keys[16], input bit d,
                                      output int ord[16]);
        for (int i = 0; i < 16; i++) ord[i] = i;
        for (int a = 0; a < n; a++) begin
            for (int b = 0; b < n - 1 - a; b++) begin
                int ca = keys[ord[b]] * 32 + ord[b];
                int cb = keys[ord[b+1]] * 32 + ord[b+1];
                int t;
                if (d ? (ca < cb) : (ca > cb)) begin
                    t = ord[b]; ord[b] = ord[b+1]; ord[b+1] = t;
                end
            end
        end
    endfunction

    // mode 0: random (with frequent ties), 1: keys 15..0 / tags A0+lane, 2: all keys 7
    task automatic gen_beat(input int mode, input bit d, output beat_t b);
        int keys[16];
        int tags[16];
        int ord[16];
        for (int i = 0; i < 16; i++) begin
            case (mode)
                1:       begin keys[i] = 15 - i; tags[i] = 160 + i; end
                2:       begin keys[i] = 7;      tags[i] = $urandom_range(0, 255); end
                default: begin
                    keys[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7)
                                                           : $urandom_range(0, 65535);
                    tags[i] = $urandom_range(0, 255);
                end
            endcase
        end
        ref_order(16, keys, d, ord);
        b.desc = d;
        for (int i = 0; i < 16; i++) begin
            b.ikey[i*KW +: KW]  = keys[i][15:0];
            b.itag[i*TW +: TW]  = tags[i][7:0];
            b.ekey[i*KW +: KW]  = keys[ord[i]][15:0];
            b.etag[i*TW +: TW]  = tags[ord[i]][7:0];
            b.elane[i*LG +: LG] = ord[i][3:0];
        end
    endtask

    // Present one beat on the main instance and wait (bounded) for out_valid.
    // Starts and ends on a falling edge; cyc = rising edges since the handshake.
    task automatic run_single(input beat_t b, output int cyc);
        in_key   = b.ikey;
        in_tag   = b.itag;
        in_desc  = b.desc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0; s2_in_valid = 1'b0; s8_in_valid = 1'b0;
        out_ready = 1'b1; s2_out_ready = 1'b1; s8_out_ready = 1'b1;
        in_key = '0; in_tag = '0; in_desc = 1'b0;
        s2_in_key = '0; s2_in_tag = '0; s2_in_desc = 1'b0;
        s8_in_key = '0; s8_in_tag = '0; s8_in_desc = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, required 0 0 1",
                     out_valid, busy, in_ready);
        end
        checks++;
        if (out_key !== '0 || out_tag !== '0 || out_lane !== '0 || out_desc !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: key=%h tag=%h lane=%h desc=%b, required all zero",
                     out_key, out_tag, out_lane, out_desc);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_ascending;
        beat_t b;
        int cyc;
        gen_beat(1, 1'b0, b);
        run_single(b, cyc);
        checks++;
        if (cyc !== LAT || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL asc_latency: got %0d cycles (valid=%b), required %0d", cyc, out_valid, LAT);
        end
        checks++;
        if (out_key !== b.ekey) begin
            errors++;
            $display("FAIL asc_key: got %h required %h", out_key, b.ekey);
        end
        checks++;
        if (out_lane !== b.elane) begin
            errors++;
            $display("FAIL asc_lane: got %h required %h", out_lane, b.elane);
        end
        checks++;
        if (out_tag !== b.etag || out_desc !== 1'b0) begin
            errors++;
            $display("FAIL asc_tag: got %h desc=%b required %h desc=0", out_tag, out_desc, b.etag);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL asc_drain: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        $display("test_ascending key=%h lane=%h", out_key, out_lane);
    endtask

    task automatic test_tie_break;
        beat_t b;
        int cyc;
        for (int d = 0; d < 2; d++) begin
            gen_beat(2, d[0], b);
            run_single(b, cyc);
            checks++;
            if (cyc !== LAT || out_lane !== b.elane || out_desc !== d[0]) begin
                errors++;
                $display("FAIL tie_lane desc=%0d: got lane=%h cyc=%0d outdesc=%b required lane=%h cyc=%0d",
                         d, out_lane, cyc, out_desc, b.elane, LAT);
            end
            checks++;
            if (out_key !== b.ekey || out_tag !== b.etag) begin
                errors++;
                $display("FAIL tie_key desc=%0d: got key=%h tag=%h required key=%h tag=%h",
                         d, out_key, out_tag, b.ekey, b.etag);
            end
            $display("test_tie_break desc=%0d lane=%h", d, out_lane);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        beat_t bb[3];
        bit    exp_v;
        int    idx;
        out_ready = 1'b1;
        gen_beat(0, 1'b0, bb[0]);
        gen_beat(0, 1'b1, bb[1]);
        gen_beat(0, 1'b0, bb[2]);
        for (int c = 0; c < 16; c++) begin
            if (c < 3) begin
                in_key = bb[c].ikey; in_tag = bb[c].itag; in_desc = bb[c].desc;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            exp_v = (c + 1 >= LAT) && (c + 1 <= LAT + 2);
            checks++;
            if (out_valid !== exp_v) begin
                errors++;
                $display("FAIL b2b_valid cycle %0d: got %b required %b", c + 1, out_valid, exp_v);
            end
            if (out_valid && exp_v) begin
                idx = c + 1 - LAT;
                checks++;
                if (out_key !== bb[idx].ekey || out_lane !== bb[idx].elane ||
                    out_tag !== bb[idx].etag || out_desc !== bb[idx].desc) begin
                    errors++;
                    $display("FAIL b2b_data beat %0d: got key=%h lane=%h required key=%h lane=%h",
                             idx, out_key, out_lane, bb[idx].ekey, bb[idx].elane);
                end
                $display("test_back_to_back beat %0d desc=%b key=%h", idx, out_desc, out_key);
            end
        end
    endtask

    task automatic test_backpressure;
        beat_t cur, e;
        beat_t q[$];
        int sent = 0, rcv = 0, cyc = 0;
        bit hold = 1'b0;
        logic [0:N*KW-1] hk;
        logic [0:N*TW-1] ht;
        logic [0:N*LG-1] hl;
        logic            hd;
        gen_beat(0, 1'($urandom_range(0, 1)), cur);
        while (rcv < 20 && cyc < 400) begin
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_key !== hk || out_tag !== ht ||
                    out_lane !== hl || out_desc !== hd) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d: valid=%b key=%h required valid=1 key=%h",
                             cyc, out_valid, out_key, hk);
                end
            end
            out_ready = ((cyc % 3) == 2);
            in_valid  = (sent < 20);
            in_key = cur.ikey; in_tag = cur.itag; in_desc = cur.desc;
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL bp_in_ready cycle %0d: got %b required %b",
                         cyc, in_ready, (!out_valid || out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: output beat %0d with empty scoreboard", rcv);
                end else begin
                    e = q.pop_front();
                    if (out_key !== e.ekey || out_tag !== e.etag ||
                        out_lane !== e.elane || out_desc !== e.desc) begin
                        errors++;
                        $display("FAIL bp_data beat %0d: got key=%h lane=%h required key=%h lane=%h",
                                 rcv, out_key, out_lane, e.ekey, e.elane);
                    end
                end
                $display("test_backpressure out beat %0d desc=%b", rcv, out_desc);
                rcv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(cur);
                sent++;
                gen_beat(0, 1'($urandom_range(0, 1)), cur);
            end
            hold = out_valid && !out_ready;
            hk = out_key; ht = out_tag; hl = out_lane; hd = out_desc;
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcv !== 20 || sent !== 20 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: sent=%0d received=%0d pending=%0d required 20 20 0",
                     sent, rcv, q.size());
        end
    endtask

    task automatic test_reset_midflight;
        beat_t b;
        int cyc;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            gen_beat(0, 1'b0, b);
            in_key = b.ikey; in_tag = b.itag; in_desc = b.desc;
            in_valid = 1'b1;
            if (c == 3) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy: busy=%b out_valid=%b required 0 0", busy, out_valid);
        end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_leak cycle %0d: out_valid=%b required 0", c, out_valid);
            end
        end
        gen_beat(0, 1'b1, b);
        run_single(b, cyc);
        checks++;
        if (cyc !== LAT || out_key !== b.ekey || out_lane !== b.elane) begin
            errors++;
            $display("FAIL midreset_next: cyc=%0d key=%h required cyc=%0d key=%h",
                     cyc, out_key, LAT, b.ekey);
        end
        $display("test_reset_midflight next beat latency=%0d", cyc);
        @(negedge clk);
    endtask

    task automatic test_param_sweep;
        int keys[16];
        int tags[16];
        int o2[16];
        int o8[16];
        bit d2, d8;
        logic [0:2*KW-1] e2k;
        logic [0:2*TW-1] e2t;
        logic [0:1]      e2l;
        logic [0:8*KW-1] e8k;
        logic [0:8*TW-1] e8t;
        logic [0:23]     e8l;
        int m;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 2))
                    0:       keys[i] = 0;
                    1:       keys[i] = 65535;
                    default: keys[i] = $urandom_range(0, 65535);
                endcase
                tags[i] = $urandom_range(0, 255);
            end
            d2 = 1'($urandom_range(0, 1));
            d8 = 1'($urandom_range(0, 1));
            ref_order(2, keys, d2, o2);
            ref_order(8, keys, d8, o8);
            for (int i = 0; i < 8; i++) begin
                s8_in_key[i*KW +: KW] = keys[i][15:0];
                s8_in_tag[i*TW +: TW] = tags[i][7:0];
                e8k[i*KW +: KW] = keys[o8[i]][15:0];
                e8t[i*TW +: TW] = tags[o8[i]][7:0];
                e8l[i*3 +: 3]   = o8[i][2:0];
            end
            for (int i = 0; i < 2; i++) begin
                s2_in_key[i*KW +: KW] = keys[i][15:0];
                s2_in_tag[i*TW +: TW] = tags[i][7:0];
                e2k[i*KW +: KW] = keys[o2[i]][15:0];
                e2t[i*TW +: TW] = tags[o2[i]][7:0];
                e2l[i +: 1]     = o2[i][0:0];
            end
            s2_in_desc = d2; s8_in_desc = d8;
            s2_in_valid = 1'b1; s8_in_valid = 1'b1;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                s2_in_valid = 1'b0; s8_in_valid = 1'b0;
                checks++;
                if (s2_out_valid !== (c == 1) || s8_out_valid !== (c == 6)) begin
                    errors++;
                    $display("FAIL sweep_valid t=%0d cycle %0d: n2=%b n8=%b required %b %b",
                             t, c, s2_out_valid, s8_out_valid, (c == 1), (c == 6));
                end
                if (c == 1 && s2_out_valid) begin
                    m = 0;
                    for (int i = 0; i < 2; i++) m |= 1 << s2_out_lane[i];
                    checks++;
                    if (s2_out_key !== e2k || s2_out_tag !== e2t || s2_out_lane !== e2l ||
                        s2_out_desc !== d2 || m != 3) begin
                        errors++;
                        $display("FAIL sweep_n2 t=%0d: key=%h lane=%b required key=%h lane=%b",
                                 t, s2_out_key, s2_out_lane, e2k, e2l);
                    end
                    $display("test_param_sweep n=2 t=%0d desc=%b key=%h", t, d2, s2_out_key);
                end
                if (c == 6 && s8_out_valid) begin
                    m = 0;
                    for (int i = 0; i < 8; i++) m |= 1 << s8_out_lane[i*3 +: 3];
                    checks++;
                    if (s8_out_key !== e8k || s8_out_tag !== e8t || s8_out_lane !== e8l ||
                        s8_out_desc !== d8 || m != 255) begin
                        errors++;
                        $display("FAIL sweep_n8 t=%0d: key=%h lane=%h required key=%h lane=%h",
                                 t, s8_out_key, s8_out_lane, e8k, e8l);
                    end
                    $display("test_param_sweep n=8 t=%0d desc=%b key=%h", t, d8, s8_out_key);
                end
            end
        end
        checks++;
        if (s2_busy !== 1'b0 || s8_busy !== 1'b0 || s2_in_ready !== 1'b1 || s8_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sweep_idle: busy=%b/%b in_ready=%b/%b required 0/0 1/1",
                     s2_busy, s8_busy, s2_in_ready, s8_in_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        test_reset();
        test_ascending();
        test_tie_break();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitonic_sort_pipe.md
Name: bitonic_sort_pipe

Overview:
Fully pipelined, flow-controlled bitonic sorting network for the packet-classification datapath. Each beat carries N keys, such as rule priorities or match costs, with a per-lane payload tag such as a rule ID. The tags travel with their keys through every compare-exchange. Sort direction is selected per beat at runtime. The block sits after field-lookup result collection and feeds the priority/best-match selection stage. It accepts one batch per cycle under backpressure.

Parameters:
N, 16, lanes per batch; power of two, >= 2
LOG_N, 4, log2(N)
KEY_WIDTH, 16, bits per sort key
TAG_WIDTH, 8, bits of payload per lane, carried unmodified with its key

Ports:
clk  input  1  clock, positive edge
reset  input  1  synchronous, active-high
in_valid  input  1  input batch valid
in_ready  output  1  block can accept a batch this cycle
in_desc  input  1  0 = ascending, 1 = descending; sampled with the batch
in_key  input  [0:N*KEY_WIDTH-1]  lane i at bits [i*KEY_WIDTH +: KEY_WIDTH]
in_tag  input  [0:N*TAG_WIDTH-1]  lane i payload
out_valid  output  1  sorted batch valid
out_ready  input  1  downstream accepts
out_desc  output  1  direction the batch was sorted with
out_key  output  [0:N*KEY_WIDTH-1]  sorted keys; lane 0 is first in order
out_tag  output  [0:N*TAG_WIDTH-1]  tags permuted identically to keys
out_lane  output  [0:N*LOG_N-1]  original input lane index of each output element
busy  output  1  any pipeline stage holds a valid batch

Behaviour:
- Network structure:
  - LOG_N merge phases. Phase p (1..LOG_N) has p compare-exchange stages, giving S = LOG_N*(LOG_N+1)/2 stages in total (10 at N=16).
  - Every stage is registered. Latency is S cycles from input handshake to out_valid when there is no stall.
- Sort order:
  - Comparison is on the internal composite {key, lane_index}, where lane_index is the LOG_N-bit original lane, attached at input. This gives a strict total order, so output is deterministic on equal keys.
  - Ascending: equal keys appear in increasing original lane. Descending: equal keys appear in decreasing original lane.
- Comparator direction:
  - Standard bitonic direction (block index bit p of element index) XOR the batch's desc bit.
  - desc travels in each stage register, so batches of mixed direction may be in flight simultaneously.
- Flow control:
  - Single global enable: en = !out_valid || out_ready. in_ready = en.
  - When en = 0, all stage registers (valid, data, desc) hold.
  - Bubbles are not compressed; stall is whole-pipe.
- Per stage:
  - On en, valid[s] <= valid[s-1], with valid[0] source = in_valid.
  - Data advances regardless of valid; downstream qualifies data with valid.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - in_valid while in_ready = 0: the batch is not taken; the source must hold.
- Reset:
  - All valid bits clear. out_valid = 0, busy = 0, in_ready = 1.
  - out_key, out_tag, out_lane and out_desc are 0.
  - Reset mid-operation discards all in-flight batches with no partial output.
- busy: OR of all stage valid bits, registered view only.
- Throughput: 1 batch/cycle when out_ready is held high.
- Widths: no arithmetic on keys; unsigned magnitude compare only. out_lane values are 0..N-1 and form a permutation per batch.

Test Plan:
- Ascending sort: N=16, keys 15..0 in lanes 0..15, tags = 0xA0+lane, desc=0 → after 10 cycles out_key = 0..15, out_lane = 15..0, out_tag = 0xAF..0xA0.
- Tie-break: all keys 0x0007, desc=0 → out_lane = 0,1,..,15. Same batch with desc=1 → out_lane = 15,..,0. Keys unchanged in both.
- Back-to-back mixed direction: 3 consecutive beats (random keys, desc=0,1,0), out_ready=1 → out_valid high on cycles 10,11,12. Each beat is sorted in its own direction; compare against a scoreboard model.
- Backpressure: stream 20 random beats; toggle out_ready with a 0,0,1 pattern → in_ready follows the en rule. No batch is lost or duplicated, order is preserved, and outputs hold stable while out_valid && !out_ready.
- Reset mid-flight: inject 4 beats, assert reset at cycle 3 for 1 cycle → out_valid never asserts for those beats. busy=0 the cycle after reset. The next injected beat emerges exactly 10 cycles later.
- Extremes/parameter sweep: keys 0xFFFF and 0x0000 mixed with N=2, LOG_N=1 (latency 1) and N=8, LOG_N=3 (latency 6) → correct order; out_lane is a valid permutation.
